trap_ctrl: RTL and testbench

- Sequences machine-mode trap entry and MRET against the CSR file's single write port.
- Accepts one trap/return request at a time from the commit stage and writes MEPC, MCAUSE, MTVAL and MSTATUS in sequence, one per cycle.
- Tracks the current privilege mode.
- Issues a one-cycle PC redirect/flush to the frontend.

---
 rtl/trap_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_trap_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap entry / MRET sequencer driving the CSR write port.
// Optional vectored interrupt redirect is enabled by defining TRAP_VECTORED_EN.
module trap_ctrl #(
  parameter int         XLEN       = 64,
  parameter logic [1:0] RESET_PRIV = 2'b11
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_kind,
  input  logic [XLEN-1:0] req_cause,
  input  logic [XLEN-1:0] req_pc,
  input  logic [XLEN-1:0] req_tval,
  input  logic [XLEN-1:0] mtvec_in,
  input  logic [XLEN-1:0] mstatus_in,
  input  logic [XLEN-1:0] mepc_in,
  output logic            csr_wen,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic [1:0]      priv
);

  localparam logic [1:0] K_EXC   = 2'b00;
  localparam logic [1:0] K_ECALL = 2'b01;
  localparam logic [1:0] K_MRET  = 2'b10;
  localparam logic [1:0] K_IRQ   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_EPC, S_CAUSE, S_TVAL, S_STATUS, S_REDIR
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      kind_q, kind_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic [XLEN-1:0] mstatus_q, mstatus_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [1:0]      priv_q, priv_d;
  logic            wen_q, wen_d;
  logic [11:0]     waddr_q, waddr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            rv_q, rv_d;
  logic [XLEN-1:0] rpc_q, rpc_d;
  logic [XLEN-1:0] status_new;
  logic [XLEN-1:0] base;

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    pc_d      = pc_q;
    cause_d   = cause_q;
    tval_d    = tval_q;
    mstatus_d = mstatus_q;
    mepc_d    = mepc_q;
    mtvec_d   = mtvec_q;
    priv_d    = priv_q;
    wen_d     = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    rv_d      = 1'b0;
    rpc_d     = rpc_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          kind_d    = req_kind;
          pc_d      = req_pc;
          mstatus_d = mstatus_in;
          mepc_d    = mepc_in;
          mtvec_d   = {mtvec_in[XLEN-1:2], 1'b0, mtvec_in[0]};
          case (req_kind)
            K_ECALL: cause_d = XLEN'({2'b10, priv_q});
            K_IRQ:   cause_d = {1'b1, req_cause[XLEN-2:0]};
            default: cause_d = req_cause;
          endcase
          tval_d  = (req_kind == K_EXC) ? req_tval : '0;
          state_d = (req_kind == K_MRET) ? S_STATUS : S_EPC;
        end
      end
      S_EPC:    state_d = S_CAUSE;
      S_CAUSE:  state_d = S_TVAL;
      S_TVAL:   state_d = S_STATUS;
      S_STATUS: state_d = S_REDIR;
      default:  state_d = S_IDLE;
    endcase

    // MSTATUS update uses the freshly latched copy so MRET can enter W_STATUS straight from IDLE.
    status_new = mstatus_d;
    if (kind_d == K_MRET) begin
      status_new[3]     = mstatus_d[7];
      status_new[7]     = 1'b1;
      status_new[12:11] = 2'b00;
    end else begin
      status_new[7]     = mstatus_d[3];
      status_new[3]     = 1'b0;
      status_new[12:11] = priv_q;
    end

    base = mtvec_q & ~XLEN'(3);

    case (state_d)
      S_EPC: begin
        wen_d   = 1'b1;
        waddr_d = 12'h341;
        wdata_d = {pc_d[XLEN-1:2], 2'b00};
      end
      S_CAUSE: begin
        wen_d   = 1'b1;
        waddr_d = 12'h342;
        wdata_d = cause_d;
      end
      S_TVAL: begin
        wen_d   = 1'b1;
        waddr_d = 12'h343;
        wdata_d = tval_d;
      end
      S_STATUS: begin
        wen_d   = 1'b1;
        waddr_d = 12'h300;
        wdata_d = status_new;
        priv_d  = (kind_d == K_MRET) ? mstatus_d[12:11] : 2'b11;
      end
      S_REDIR: begin
        rv_d = 1'b1;
        if (kind_q == K_MRET) begin
          rpc_d = mepc_q;
        end else begin
          rpc_d = base;
`ifdef TRAP_VECTORED_EN
          if (mtvec_q[1:0] == 2'b01 && kind_q == K_IRQ)
            rpc_d = base + XLEN'({cause_q[5:0], 2'b00});
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      kind_q    <= '0;
      pc_q      <= '0;
      cause_q   <= '0;
      tval_q    <= '0;
      mstatus_q <= '0;
      mepc_q    <= '0;
      mtvec_q   <= '0;
      priv_q    <= RESET_PRIV;
      wen_q     <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      rv_q      <= 1'b0;
      rpc_q     <= '0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      pc_q      <= pc_d;
      cause_q   <= cause_d;
      tval_q    <= tval_d;
      mstatus_q <= mstatus_d;
      mepc_q    <= mepc_d;
      mtvec_q   <= mtvec_d;
      priv_q    <= priv_d;
      wen_q     <= wen_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      rv_q      <= rv_d;
      rpc_q     <= rpc_d;
    end
  end

  assign req_ready      = (state_q == S_IDLE);
  assign csr_wen        = wen_q;
  assign csr_waddr      = waddr_q;
  assign csr_wdata      = wdata_q;
  assign redirect_valid = rv_q;
  assign redirect_pc    = rpc_q;
  assign priv           = priv_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - self-checking bench for trap_ctrl with a per-cycle expectation model.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_kind;
  logic [63:0] req_cause, req_pc, req_tval, mtvec_in, mstatus_in, mepc_in;
  logic        csr_wen;
  logic [11:0] csr_waddr;
  logic [63:0] csr_wdata;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [1:0]  priv;

  trap_ctrl dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .req_cause(req_cause), .req_pc(req_pc), .req_tval(req_tval),
    .mtvec_in(mtvec_in), .mstatus_in(mstatus_in), .mepc_in(mepc_in),
    .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .priv(priv)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic        wen;
    logic [11:0] addr;
    logic [63:0] data;
    logic        rv;
    logic [63:0] rpc;
    logic        chkp;
    logic [1:0]  priv;
  } exp_t;

  typedef struct {
    logic [11:0] addr;
    logic [63:0] data;
    int          cyc;
  } wr_t;

  exp_t        expq[$];
  wr_t         wlog[$];
  logic [63:0] rlog[$];
  int          rcyc[$];
  logic [1:0]  m_priv;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic wen, input logic [11:0] a, input logic [63:0] d,
                              input logic rv, input logic [63:0] rpc,
                              input logic chkp, input logic [1:0] p);
    exp_t e;
    e.wen = wen; e.addr = a; e.data = d; e.rv = rv; e.rpc = rpc; e.chkp = chkp; e.priv = p;
    return e;
  endfunction

  // Build the cycle-by-cycle outputs one accepted request must produce.
  task automatic model_accept();
    logic [63:0] cause, tval, ms, base, tgt;
    logic [1:0]  np;
    base = {mtvec_in[63:2], 2'b00};
    if (req_kind == 2'b10) begin
      ms     = mstatus_in;
      np     = mstatus_in[12:11];
      ms[3]  = mstatus_in[7];
      ms[7]  = 1'b1;
      ms[12:11] = 2'b00;
      expq.push_back(mk(1, 12'h300, ms, 0, 0, 0, 0));
      expq.push_back(mk(0, 0, 0, 1, mepc_in, 1, np));
    end else begin
      if (req_kind == 2'b01) cause = 64'd8 + 64'(m_priv);
      else if (req_kind == 2'b11) cause = req_cause | (64'd1 << 63);
      else cause = req_cause;
      tval = (req_kind == 2'b00) ? req_tval : 64'd0;
      ms = mstatus_in;
      ms[7] = mstatus_in[3];
      ms[3] = 1'b0;
      ms[12:11] = m_priv;
      tgt = base;
`ifdef TRAP_VECTORED_EN
      if (mtvec_in[1:0] == 2'b01 && req_kind == 2'b11) tgt = base + 64'd4 * 64'(cause[5:0]);
`endif
      np = 2'b11;
      expq.push_back(mk(1, 12'h341, req_pc & ~64'd3, 0, 0, 1, m_priv));
      expq.push_back(mk(1, 12'h342, cause, 0, 0, 1, m_priv));
      expq.push_back(mk(1, 12'h343, tval, 0, 0, 1, m_priv));
      expq.push_back(mk(1, 12'h300, ms, 0, 0, 0, 0));
      expq.push_back(mk(0, 0, 0, 1, tgt, 1, np));
    end
    m_priv = np;
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      expq.delete();
      m_priv = 2'b11;
    end else begin
      if (expq.size() != 0) void'(expq.pop_front());
      else if (req_valid) model_accept();
    end
  end

  always @(negedge clk) begin
    if (!resetn) begin
      chk("rst_wen", 64'(csr_wen), 0);
      chk("rst_waddr", 64'(csr_waddr), 0);
      chk("rst_wdata", csr_wdata, 0);
      chk("rst_rv", 64'(redirect_valid), 0);
      chk("rst_rpc", redirect_pc, 0);
      chk("rst_priv", 64'(priv), 3);
      chk("rst_ready", 64'(req_ready), 1);
    end else begin
      if (csr_wen) wlog.push_back('{csr_waddr, csr_wdata, cyc});
      if (redirect_valid) begin rlog.push_back(redirect_pc); rcyc.push_back(cyc); end
      if (expq.size() != 0) begin
        chk("ready_busy", 64'(req_ready), 0);
        chk("wen", 64'(csr_wen), 64'(expq[0].wen));
        if (expq[0].wen) begin
          chk("waddr", 64'(csr_waddr), 64'(expq[0].addr));
          chk("wdata", csr_wdata, expq[0].data);
        end
        chk("rv", 64'(redirect_valid), 64'(expq[0].rv));
        if (expq[0].rv) chk("rpc", redirect_pc, expq[0].rpc);
        if (expq[0].chkp) chk("priv", 64'(priv), 64'(expq[0].priv));
      end else begin
        chk("ready_idle", 64'(req_ready), 1);
        chk("wen_idle", 64'(csr_wen), 0);
        chk("rv_idle", 64'(redirect_valid), 0);
        chk("priv_idle", 64'(priv), 64'(m_priv));
      end
    end
  end

  task automatic issue(input logic [1:0] k, input logic [63:0] c, input logic [63:0] pc,
                       input logic [63:0] tv, input logic [63:0] tvec,
                       input logic [63:0] ms, input logic [63:0] epc);
    wlog.delete(); rlog.delete(); rcyc.delete();
    @(negedge clk); #1;
    req_kind = k; req_cause = c; req_pc = pc; req_tval = tv;
    mtvec_in = tvec; mstatus_in = ms; mepc_in = epc; req_valid = 1'b1;
    @(negedge clk); #1;
    req_valid = 1'b0;
    // Scramble the sampled-at-accept inputs while the sequence is in flight.
    mtvec_in = 64'h0; mstatus_in = '1; mepc_in = 64'h0;
    req_cause = '1; req_pc = '1; req_tval = '1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    resetn = 1'b0; req_valid = 1'b0; req_kind = 0;
    req_cause = 0; req_pc = 0; req_tval = 0; mtvec_in = 0; mstatus_in = 0; mepc_in = 0;
    repeat (3) @(negedge clk);
    #1 resetn = 1'b1;

    issue(2'b00, 64'd2, 64'h80000104, 64'hdeadbeef, 64'h80001000, 64'h8, 64'h0);
    chk("exc_nwr", 64'(wlog.size()), 4);
    if (wlog.size() == 4) begin
      chk("exc_a0", 64'(wlog[0].addr), 64'h341); chk("exc_d0", wlog[0].data, 64'h80000104);
      chk("exc_a1", 64'(wlog[1].addr), 64'h342); chk("exc_d1", wlog[1].data, 64'd2);
      chk("exc_a2", 64'(wlog[2].addr), 64'h343); chk("exc_d2", wlog[2].data, 64'hdeadbeef);
      chk("exc_a3", 64'(wlog[3].addr), 64'h300); chk("exc_d3", wlog[3].data, 64'h1880);
    end
    chk("exc_nrd", 64'(rlog.size()), 1);
    if (rlog.size() == 1) begin
      chk("exc_rpc", rlog[0], 64'h80001000);
      if (wlog.size() != 0) chk("exc_rlat", 64'(rcyc[0] - wlog[0].cyc), 4);
    end

    issue(2'b10, 64'd0, 64'h0, 64'h0, 64'h80001000, 64'h80, 64'h80000300);
    chk("mret_u_priv", 64'(priv), 0);
    if (wlog.size() != 0) chk("mret_u_st", wlog[0].data, 64'h88);

    issue(2'b01, 64'd0, 64'h80000300, 64'h55, 64'h80001000, 64'h0, 64'h0);
    chk("ecall_nwr", 64'(wlog.size()), 4);
    if (wlog.size() == 4) begin
      chk("ecall_cause", wlog[1].data, 64'd8);
      chk("ecall_tval", wlog[2].data, 64'd0);
      chk("ecall_mpp", 64'(wlog[3].data[12:11]), 0);
    end
    chk("ecall_priv", 64'(priv), 3);

    issue(2'b10, 64'd0, 64'h0, 64'h0, 64'h80001000, 64'h1880, 64'h80000200);
    chk("mret_nwr", 64'(wlog.size()), 1);
    if (wlog.size() == 1) chk("mret_st", wlog[0].data, 64'h88);
    if (rlog.size() == 1) begin
      chk("mret_rpc", rlog[0], 64'h80000200);
      if (wlog.size() != 0) chk("mret_rlat", 64'(rcyc[0] - wlog[0].cyc), 1);
    end else chk("mret_nrd", 64'(rlog.size()), 1);
    chk("mret_priv", 64'(priv), 3);

    issue(2'b11, 64'd7, 64'h80000500, 64'h0, 64'h80001001, 64'h8, 64'h0);
    if (wlog.size() >= 2) chk("irq_cause", wlog[1].data, 64'h8000000000000007);
    else chk("irq_nwr", 64'(wlog.size()), 4);
    if (rlog.size() == 1) begin
`ifdef TRAP_VECTORED_EN
      chk("irq_rpc", rlog[0], 64'h8000101C);
`else
      chk("irq_rpc", rlog[0], 64'h80001000);
`endif
    end else chk("irq_nrd", 64'(rlog.size()), 1);

    wlog.delete(); rlog.delete(); rcyc.delete();
    @(negedge clk); #1;
    req_kind = 2'b00; req_cause = 64'd5; req_pc = 64'h80000400; req_tval = 64'h11;
    mtvec_in = 64'h80002000; mstatus_in = 64'h8; mepc_in = 64'h0; req_valid = 1'b1;
    repeat (7) @(negedge clk);
    #1 req_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("b2b_nwr", 64'(wlog.size()), 8);
    if (wlog.size() == 8) chk("b2b_gap", 64'(wlog[4].cyc - wlog[0].cyc), 6);

    wlog.delete(); rlog.delete(); rcyc.delete();
    @(negedge clk); #1;
    req_kind = 2'b00; req_cause = 64'd4; req_pc = 64'h80000600; req_tval = 64'h22;
    mtvec_in = 64'h80003000; mstatus_in = 64'h8; req_valid = 1'b1;
    @(negedge clk); #1 req_valid = 1'b0;
    @(negedge clk); #1 resetn = 1'b0;
    @(negedge clk); #1 resetn = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_nwr", 64'(wlog.size()), 2);
    chk("abort_nrd", 64'(rlog.size()), 0);
    chk("abort_priv", 64'(priv), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
